// File: rtl/wac_cmd_sched.sv
// Command scheduler: syncs strobe-bus bytes into 3-byte frames, applies register
// commands and queues serial jobs for a single shared serializer.
module wac_cmd_sched #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TIMEOUT_CYC = 1000,
  parameter logic [7:0]  KEY_BYTE    = 8'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  busIn,
  input  logic        dataStb,
  input  logic        serDone,
  output logic        serStart,
  output logic [1:0]  serTarget,
  output logic [15:0] serWord,
  output logic [4:0]  mux,
  output logic [15:0] theBeanConf,
  output logic        stmBusy,
  output logic        errFlag,
  output logic        ovfFlag,
  output logic [7:0]  frameCnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic [1:0]  tgt;
    logic [15:0] word;
  } job_t;

  typedef enum logic [1:0] {P_IDLE, P_KEY, P_DATA} pstate_e;
  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_WAIT} dstate_e;

  // ---------------- input sync ----------------
  logic [7:0] bus_q, bus_d;
  logic [2:0] strb_q, strb_d;
  logic [7:0] byte_q, byte_d;
  logic       cmt_q, cmt_d;
  logic [7:0] cmt_byte_q, cmt_byte_d;

  always_comb begin
    bus_d      = busIn;
    strb_d     = {strb_q[1:0], dataStb};
    byte_d     = strb_q[1] ? byte_q : bus_q;
    cmt_d      = strb_q[1] & ~strb_q[2];
    cmt_byte_d = byte_q;
  end

  // ---------------- parser ----------------
  pstate_e     pst_q, pst_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [4:0]  mux_q, mux_d;
  logic [15:0] conf_q, conf_d;
  logic        err_q, err_d;
  logic [7:0]  frame_q, frame_d;
  logic        push;
  job_t        push_job;

  always_comb begin
    pst_d    = pst_q;
    cmd_d    = cmd_q;
    gap_d    = '0;
    mux_d    = mux_q;
    conf_d   = conf_q;
    err_d    = err_q;
    frame_d  = frame_q;
    push     = 1'b0;
    push_job = '0;
    case (pst_q)
      P_IDLE: begin
        if (cmt_q) begin
          cmd_d = cmt_byte_q;
          pst_d = P_KEY;
        end
      end
      P_KEY: begin
        if (cmt_q) begin
          if (cmt_byte_q == KEY_BYTE) begin
            pst_d = P_DATA;
          end else begin
            err_d = 1'b1;
            pst_d = P_IDLE;
          end
        end else if (gap_q == GAP_W'(TIMEOUT_CYC)) begin
          err_d = 1'b1;
          pst_d = P_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      P_DATA: begin
        if (cmt_q) begin
          pst_d   = P_IDLE;
          frame_d = frame_q + 8'd1;
          case (cmd_q)
            8'h01: mux_d = cmt_byte_q[4:0];
            8'h02: begin
              push     = 1'b1;
              push_job = '{tgt: 2'd0, word: {4'h0, cmt_byte_q, 4'h0}};
            end
            8'h03, 8'h04, 8'h05: begin
              push     = 1'b1;
              push_job = '{tgt: cmd_q[1:0] - 2'd2, word: {8'h11, cmt_byte_q}};
            end
            8'h06: conf_d[7:0]  = cmt_byte_q;
            8'h07: conf_d[15:8] = cmt_byte_q;
            default: begin
              err_d   = 1'b1;
              frame_d = frame_q;
            end
          endcase
        end else if (gap_q == GAP_W'(TIMEOUT_CYC)) begin
          err_d = 1'b1;
          pst_d = P_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: pst_d = P_IDLE;
    endcase
  end

  // ---------------- job FIFO + dispatcher ----------------
  job_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             pop, push_ok;
  dstate_e          dst_q, dst_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [15:0]      word_q, word_d;
  logic             busy_q, busy_d;

  always_comb begin
    pop      = (dst_q == D_IDLE) && (cnt_q != '0);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    push_ok  = push && ((cnt_q != CNT_W'(FIFO_DEPTH)) || pop);
    ovf_d    = ovf_q | (push & ~push_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    dst_d  = dst_q;
    tgt_d  = tgt_q;
    word_d = word_q;
    case (dst_q)
      D_IDLE: begin
        if (pop) begin
          tgt_d  = mem_q[rd_ptr_q].tgt;
          word_d = mem_q[rd_ptr_q].word;
          dst_d  = D_ISSUE;
        end
      end
      D_ISSUE: dst_d = D_WAIT;
      D_WAIT:  if (serDone) dst_d = D_IDLE;
      default: dst_d = D_IDLE;
    endcase

    busy_d = (pst_q != P_IDLE) | (cnt_q != '0) | (dst_q != D_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_job;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q      <= '0;
      // Sync chain resets to the idle-high strobe level so reset never fakes an edge.
      strb_q     <= 3'b111;
      byte_q     <= '0;
      cmt_q      <= 1'b0;
      cmt_byte_q <= '0;
      pst_q      <= P_IDLE;
      cmd_q      <= '0;
      gap_q      <= '0;
      mux_q      <= '0;
      conf_q     <= '0;
      err_q      <= 1'b0;
      frame_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      dst_q      <= D_IDLE;
      tgt_q      <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      bus_q      <= bus_d;
      strb_q     <= strb_d;
      byte_q     <= byte_d;
      cmt_q      <= cmt_d;
      cmt_byte_q <= cmt_byte_d;
      pst_q      <= pst_d;
      cmd_q      <= cmd_d;
      gap_q      <= gap_d;
      mux_q      <= mux_d;
      conf_q     <= conf_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      dst_q      <= dst_d;
      tgt_q      <= tgt_d;
      word_q     <= word_d;
      busy_q     <= busy_d;
    end
  end

  assign serStart    = (dst_q == D_ISSUE);
  assign serTarget   = tgt_q;
  assign serWord     = word_q;
  assign mux         = mux_q;
  assign theBeanConf = conf_q;
  assign stmBusy     = busy_q;
  assign errFlag     = err_q;
  assign ovfFlag     = ovf_q;
  assign frameCnt    = frame_q;

endmodule

// File: tb/tb_wac_cmd_sched.sv
// Bench for wac_cmd_sched: directed frames, expected serial jobs go to a
// scoreboard queue checked by a monitor on every serStart.
module tb_wac_cmd_sched;
  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  busIn = 8'h00;
  logic        dataStb = 1'b1;
  logic        serDone = 1'b0;
  logic        serStart;
  logic [1:0]  serTarget;
  logic [15:0] serWord;
  logic [4:0]  mux;
  logic [15:0] theBeanConf;
  logic        stmBusy, errFlag, ovfFlag;
  logic [7:0]  frameCnt;

  typedef struct packed {
    logic [1:0]  tgt;
    logic [15:0] word;
  } job_t;

  job_t exp_q[$];
  int   errors = 0, checks = 0, n_starts = 0, stray = 0, done_wait = 0;
  bit   in_flight = 1'b0, auto_done = 1'b0;

  wac_cmd_sched #(.FIFO_DEPTH(4), .TIMEOUT_CYC(TO), .KEY_BYTE(8'h55)) dut (
    .clk(clk), .rst(rst), .busIn(busIn), .dataStb(dataStb), .serDone(serDone),
    .serStart(serStart), .serTarget(serTarget), .serWord(serWord), .mux(mux),
    .theBeanConf(theBeanConf), .stmBusy(stmBusy), .errFlag(errFlag),
    .ovfFlag(ovfFlag), .frameCnt(frameCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every serStart must match the oldest expected job.
  always @(negedge clk) begin
    if (!rst && serStart) begin
      chk("single job in flight", {31'd0, in_flight}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected serStart: got tgt=%0d word=%0h expected none", serTarget, serWord);
      end else begin
        job_t e;
        e = exp_q.pop_front();
        chk("serTarget", {30'd0, serTarget}, {30'd0, e.tgt});
        chk("serWord", {16'd0, serWord}, {16'd0, e.word});
      end
      in_flight = 1'b1;
      n_starts++;
    end
  end

  // Serializer model: answers serDone 30 cycles after start, or emits stray pulses.
  always @(negedge clk) begin
    serDone = 1'b0;
    if (stray > 0) begin
      serDone = 1'b1;
      stray--;
    end else if (in_flight && auto_done) begin
      done_wait++;
      if (done_wait == 30) begin
        serDone   = 1'b1;
        in_flight = 1'b0;
        done_wait = 0;
      end
    end
  end

  task automatic strobe_byte(input logic [7:0] b);
    @(posedge clk); #2;
    busIn   = b;
    dataStb = 1'b0;
    #10;
    dataStb = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    strobe_byte(b);
    #18;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] k, input logic [7:0] d);
    send_byte(c);
    send_byte(k);
    send_byte(d);
  endtask

  task automatic push_exp(input logic [1:0] t, input logic [15:0] w);
    job_t j;
    j.tgt  = t;
    j.word = w;
    exp_q.push_back(j);
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget && n_starts < n; i++) @(posedge clk);
    chk("serStart count", n_starts, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    in_flight = 1'b0;
    done_wait = 0;
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst mux", mux, 0);
    chk("rst theBeanConf", theBeanConf, 0);
    chk("rst serStart", serStart, 0);
    chk("rst serWord", serWord, 0);
    chk("rst flags", {errFlag, ovfFlag, stmBusy}, 0);
    chk("rst frameCnt", frameCnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Frame 01,55,1F with exact latency on the third strobe
    send_byte(8'h01);
    send_byte(8'h55);
    strobe_byte(8'h1F);
    @(posedge clk);                 // edge N
    @(posedge clk);                 // N+1
    @(posedge clk); #1;             // N+2
    chk("mux before N+3", mux, 0);
    @(posedge clk); #1;             // N+3
    chk("mux at N+3", mux, 5'h1F);
    chk("frameCnt at N+3", frameCnt, 1);
    repeat (6) @(posedge clk); #1;
    chk("stmBusy idle after reg cmd", stmBusy, 0);
    chk("no serStart for reg cmd", n_starts, 0);

    // Two serial jobs, serializer answers after 30 cycles
    push_exp(2'd0, 16'h0770);
    push_exp(2'd1, 16'h11A5);
    auto_done = 1'b1;
    send_frame(8'h02, 8'h55, 8'h77);
    send_frame(8'h03, 8'h55, 8'hA5);
    wait_starts(2, 300);
    repeat (40) @(posedge clk); #1;
    chk("frameCnt after jobs", frameCnt, 3);
    chk("stmBusy after jobs", stmBusy, 0);
    chk("scoreboard drained 1", exp_q.size(), 0);

    // Bad key; trailing EE starts a frame that must time out
    send_frame(8'h04, 8'hAA, 8'hEE);
    repeat (5) @(posedge clk); #1;
    chk("errFlag bad key", errFlag, 1);
    chk("frameCnt bad key", frameCnt, 3);
    repeat (TO + 20) @(posedge clk);
    send_frame(8'h06, 8'h55, 8'h3C);
    repeat (6) @(posedge clk); #1;
    chk("theBeanConf lo", theBeanConf, 16'h003C);
    chk("frameCnt after conf", frameCnt, 4);
    chk("ovfFlag clear", ovfFlag, 0);
    chk("no push on bad key", n_starts, 2);

    // Overflow: one in flight + 4 queued, sixth dropped
    auto_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(i);
      if (i < 5) push_exp(2'd0, {4'h0, d, 4'h0});
      send_frame(8'h02, 8'h55, d);
    end
    repeat (6) @(posedge clk); #1;
    chk("ovfFlag set", ovfFlag, 1);
    chk("only one started while held", n_starts, 3);
    chk("frameCnt counts dropped frame", frameCnt, 10);
    chk("stmBusy while held", stmBusy, 1);
    auto_done = 1'b1;
    wait_starts(7, 600);
    repeat (40) @(posedge clk); #1;
    chk("scoreboard drained 2", exp_q.size(), 0);
    chk("stmBusy after drain", stmBusy, 0);

    // Timeout after a lone command byte
    auto_done = 1'b0;
    do_reset();
    #1;
    chk("errFlag cleared by rst", errFlag, 0);
    chk("ovfFlag cleared by rst", ovfFlag, 0);
    send_byte(8'h02);
    repeat (900) @(posedge clk); #1;
    chk("errFlag before timeout", errFlag, 0);
    chk("stmBusy partial frame", stmBusy, 1);
    repeat (120) @(posedge clk); #1;
    chk("errFlag timeout", errFlag, 1);
    chk("stmBusy after timeout", stmBusy, 0);
    send_frame(8'h07, 8'h55, 8'h12);
    repeat (6) @(posedge clk); #1;
    chk("theBeanConf hi", theBeanConf, 16'h1200);
    chk("frameCnt after timeout", frameCnt, 1);

    // Reset while a job is in flight and two are queued
    base = n_starts;
    push_exp(2'd0, 16'h0210);
    send_frame(8'h02, 8'h55, 8'h21);
    send_frame(8'h02, 8'h55, 8'h22);
    send_frame(8'h02, 8'h55, 8'h23);
    repeat (6) @(posedge clk); #1;
    chk("one start before rst", n_starts, base + 1);
    chk("stmBusy before rst", stmBusy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst serStart", serStart, 0);
    chk("rst serWord mid-job", serWord, 0);
    chk("rst frameCnt mid-job", frameCnt, 0);
    chk("rst stmBusy mid-job", stmBusy, 0);
    @(negedge clk);
    rst       = 1'b0;
    in_flight = 1'b0;
    stray     = 3;
    repeat (50) @(posedge clk); #1;
    chk("no start after rst", n_starts, base + 1);
    chk("stmBusy after rst", stmBusy, 0);
    chk("scoreboard drained 3", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
